// File: rtl/and_or_sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | and_or_sched_pkg                                                 |
// | Shared state encodings and op codes for the AND/OR scheduler.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package and_or_sched_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic OP_AND = 1'b1;
  localparam logic OP_OR  = 1'b0;

endpackage
`default_nettype wire

// File: rtl/logic_op_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | logic_op_unit                                                    |
// | Combinational bitwise AND/OR unit shared by both requesters.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module logic_op_unit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             isAnd,
  output logic [WIDTH-1:0] y
);
  import and_or_sched_pkg::*;

  always @* begin
    y = (isAnd == OP_OR) ? (a | b) : (a & b);
  end

endmodule
`default_nettype wire

// File: rtl/and_or_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | and_or_scheduler                                                 |
// | Round-robin sharing of one AND/OR unit between two requesters,   |
// | with a registered valid/ready response and saturating op counts. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module and_or_scheduler #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0Valid,
  output logic             req0Ready,
  input  logic [WIDTH-1:0] req0A,
  input  logic [WIDTH-1:0] req0B,
  input  logic             req0Op,
  input  logic             req1Valid,
  output logic             req1Ready,
  input  logic [WIDTH-1:0] req1A,
  input  logic [WIDTH-1:0] req1B,
  input  logic             req1Op,
  output logic             rspValid,
  input  logic             rspReady,
  output logic [WIDTH-1:0] rspData,
  output logic             rspIsAnd,
  output logic             rspId,
  output logic [CNT_W-1:0] andCount,
  output logic [CNT_W-1:0] orCount
);
  import and_or_sched_pkg::*;

  logic [1:0]       state_q, state_d;
  logic             rrPtr_q;
  logic [WIDTH-1:0] opA_q, opB_q;
  logic             opAnd_q, opId_q;
  logic             rspValid_q, rspIsAnd_q, rspId_q;
  logic [WIDTH-1:0] rspData_q;
  logic [CNT_W-1:0] andCount_q, orCount_q;
  logic             grant;
  logic             accept;
  logic [WIDTH-1:0] unitY;

  // rrPtr holds the last winner, so a tie goes to the other requester.
  always_comb begin
    grant = 1'b0;
    if (req0Valid && req1Valid) begin
      grant = ~rrPtr_q;
    end else if (req1Valid) begin
      grant = 1'b1;
    end
  end

  assign accept    = !rst && (state_q == ST_IDLE) && (req0Valid || req1Valid);
  assign req0Ready = accept && !grant;
  assign req1Ready = accept && grant;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)   state_d = ST_EXEC;
      ST_EXEC:               state_d = ST_RESP;
      ST_RESP: if (rspReady) state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  logic_op_unit #(.WIDTH(WIDTH)) u_unit (
    .a     (opA_q),
    .b     (opB_q),
    .isAnd (opAnd_q),
    .y     (unitY)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rrPtr_q    <= 1'b1;
      opA_q      <= '0;
      opB_q      <= '0;
      opAnd_q    <= 1'b0;
      opId_q     <= 1'b0;
      rspValid_q <= 1'b0;
      rspData_q  <= '0;
      rspIsAnd_q <= 1'b0;
      rspId_q    <= 1'b0;
      andCount_q <= '0;
      orCount_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        opA_q   <= grant ? req1A : req0A;
        opB_q   <= grant ? req1B : req0B;
        opAnd_q <= grant ? req1Op : req0Op;
        opId_q  <= grant;
        rrPtr_q <= grant;
      end
      if (state_q == ST_EXEC) begin
        rspData_q  <= unitY;
        rspIsAnd_q <= opAnd_q;
        rspId_q    <= opId_q;
        rspValid_q <= 1'b1;
        if (opAnd_q == OP_AND) begin
          if (andCount_q != {CNT_W{1'b1}}) andCount_q <= andCount_q + CNT_W'(1);
        end else begin
          if (orCount_q != {CNT_W{1'b1}}) orCount_q <= orCount_q + CNT_W'(1);
        end
      end
      if ((state_q == ST_RESP) && rspReady) begin
        rspValid_q <= 1'b0;
      end
    end
  end

  assign rspValid = rspValid_q;
  assign rspData  = rspData_q;
  assign rspIsAnd = rspIsAnd_q;
  assign rspId    = rspId_q;
  assign andCount = andCount_q;
  assign orCount  = orCount_q;

endmodule
`default_nettype wire
